decode_issue: RTL and testbench

Decode/issue stage directly downstream of the instruction fetch memory. Accepts one 32-bit instruction word plus its 5-bit PC per handshake and splits it into fields. Reads the 32x32 register file, extends the immediate and holds the result in a single output register for the execute stage. A busy-bit scoreboard stalls read-after-write hazards until writeback.

---
 rtl/decode_pkg.sv | 75 +++++++
 rtl/reg_file.sv | 45 ++++
 rtl/decode_issue.sv | 178 +++++++++++++++++
 tb/tb_decode_issue.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode map, instruction classes and field positions for decode_issue
package decode_pkg;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_ADDU  = 6'd2;
  localparam logic [5:0] OP_SUBU  = 6'd3;
  localparam logic [5:0] OP_ADDI  = 6'd4;
  localparam logic [5:0] OP_ADDIU = 6'd5;
  localparam logic [5:0] OP_AND   = 6'd6;
  localparam logic [5:0] OP_OR    = 6'd7;
  localparam logic [5:0] OP_ANDI  = 6'd8;
  localparam logic [5:0] OP_ORI   = 6'd9;
  localparam logic [5:0] OP_SLL   = 6'd10;
  localparam logic [5:0] OP_SRL   = 6'd11;
  localparam logic [5:0] OP_LW    = 6'd12;
  localparam logic [5:0] OP_SW    = 6'd13;
  localparam logic [5:0] OP_BEQ   = 6'd14;
  localparam logic [5:0] OP_BNE   = 6'd15;
  localparam logic [5:0] OP_BGT   = 6'd16;
  localparam logic [5:0] OP_BGTE  = 6'd17;
  localparam logic [5:0] OP_BLE   = 6'd18;
  localparam logic [5:0] OP_BLEQ  = 6'd19;
  localparam logic [5:0] OP_J     = 6'd20;
  localparam logic [5:0] OP_JR    = 6'd21;
  localparam logic [5:0] OP_JAL   = 6'd22;
  localparam logic [5:0] OP_SLT   = 6'd23;
  localparam logic [5:0] OP_SLTI  = 6'd24;
  localparam logic [5:0] OP_MAX   = 6'd24;

  // Link register written by jal
  localparam logic [4:0] REG_LINK = 5'd31;

  // Instruction field bit positions
  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int TGT_HI   = 25;
  localparam int TGT_LO   = 0;

  typedef enum logic [3:0] {
    R_ALU, I_ALU, SHIFT, LOAD, STORE, BRANCH, JUMP, JR, JAL, ILLEGAL
  } iclass_e;

  function automatic iclass_e classify(logic [5:0] op);
    if (op > OP_MAX) return ILLEGAL;
    case (op)
      OP_ADD, OP_SUB, OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_SLT: return R_ALU;
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI:             return I_ALU;
      OP_SLL, OP_SRL:                                          return SHIFT;
      OP_LW:                                                   return LOAD;
      OP_SW:                                                   return STORE;
      OP_BEQ, OP_BNE, OP_BGT, OP_BGTE, OP_BLE, OP_BLEQ:        return BRANCH;
      OP_J:                                                    return JUMP;
      OP_JR:                                                   return JR;
      OP_JAL:                                                  return JAL;
      default:                                                 return ILLEGAL;
    endcase
  endfunction

  // Logical immediates are zero-extended; everything else sign-extends
  function automatic logic imm_zero_ext(logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32-entry register file, two async read ports, one write port
// Ports:
//   clk_i, rst_ni            clock, async active-low reset (clears all entries)
//   we_i, waddr_i, wdata_i   write port; writes to r0 are ignored
//   raddr_a_i / rdata_a_o    read port A
//   raddr_b_i / rdata_b_o    read port B
// Reads of r0 return zero; a same-cycle write to a read address is bypassed.
module reg_file
  import decode_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [4:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [4:0]        raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [4:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [32];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(logic [4:0] a, logic we, logic [4:0] wa,
                                                logic [DATA_W-1:0] wd,
                                                logic [DATA_W-1:0] stored);
    if (a == 5'd0)           return '0;
    else if (we && (wa == a)) return wd;
    else                     return stored;
  endfunction

  assign rdata_a_o = rd_port(raddr_a_i, we_i, waddr_i, wdata_i, mem_q[raddr_a_i]);
  assign rdata_b_o = rd_port(raddr_b_i, we_i, waddr_i, wdata_i, mem_q[raddr_b_i]);

endmodule

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - decode/issue stage with busy-bit scoreboard and one output register
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   in_valid_i/in_ready_o            fetch handshake; in_instr_i, in_pc_i payload
//   out_valid_o/out_ready_i          execute handshake
//   out_opcode_o .. out_illegal_o    decoded bundle (registered)
//   flush_i                          drop held bundle, block intake this cycle
//   wb_en_i, wb_addr_i, wb_data_i    register writeback, clears busy bit
module decode_issue
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_instr_i,
  input  logic [PC_W-1:0]   in_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [5:0]        out_opcode_o,
  output logic [DATA_W-1:0] out_rs_val_o,
  output logic [DATA_W-1:0] out_rt_val_o,
  output logic [DATA_W-1:0] out_imm_o,
  output logic [4:0]        out_shamt_o,
  output logic [25:0]       out_target_o,
  output logic [4:0]        out_dest_o,
  output logic              out_wen_o,
  output logic [PC_W-1:0]   out_pc_o,
  output logic              out_illegal_o,
  input  logic              flush_i,
  input  logic              wb_en_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i
);

  typedef struct packed {
    logic [5:0]        opcode;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm;
    logic [4:0]        shamt;
    logic [25:0]       target;
    logic [4:0]        dest;
    logic              wen;
    logic [PC_W-1:0]   pc;
    logic              illegal;
  } bundle_t;

  // Field extraction
  logic [5:0]  opcode;
  logic [4:0]  rs_a, rt_a, rd_a;
  logic [15:0] imm16;
  iclass_e     cls;

  assign opcode = in_instr_i[OPC_HI:OPC_LO];
  assign rs_a   = in_instr_i[RS_HI:RS_LO];
  assign rt_a   = in_instr_i[RT_HI:RT_LO];
  assign rd_a   = in_instr_i[RD_HI:RD_LO];
  assign imm16  = in_instr_i[IMM_HI:IMM_LO];
  assign cls    = classify(opcode);

  // Operand usage and destination per class
  logic       use_rs, use_rt, has_dest;
  logic [4:0] dest;

  always_comb begin
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    has_dest = 1'b0;
    dest     = 5'd0;
    case (cls)
      R_ALU:         begin use_rs = 1'b1; use_rt = 1'b1; has_dest = 1'b1; dest = rd_a; end
      I_ALU, LOAD:   begin use_rs = 1'b1; has_dest = 1'b1; dest = rt_a; end
      SHIFT:         begin use_rt = 1'b1; has_dest = 1'b1; dest = rd_a; end
      STORE, BRANCH: begin use_rs = 1'b1; use_rt = 1'b1; end
      JR:            use_rs = 1'b1;
      JAL:           begin has_dest = 1'b1; dest = REG_LINK; end
      JUMP, ILLEGAL: ;
      default:       ;
    endcase
  end

  // Register file with writeback bypass
  logic [DATA_W-1:0] rf_rs, rf_rt;

  reg_file #(.DATA_W(DATA_W)) u_reg_file (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .we_i      (wb_en_i),
    .waddr_i   (wb_addr_i),
    .wdata_i   (wb_data_i),
    .raddr_a_i (rs_a),
    .rdata_a_o (rf_rs),
    .raddr_b_i (rt_a),
    .rdata_b_o (rf_rt)
  );

  // Output register and scoreboard state
  bundle_t     bundle_q, dec_bundle;
  logic        out_valid_q, out_valid_d;
  logic [31:0] busy_q, busy_d;

  always_comb begin
    dec_bundle         = '0;
    dec_bundle.opcode  = opcode;
    dec_bundle.rs_val  = use_rs ? rf_rs : '0;
    dec_bundle.rt_val  = use_rt ? rf_rt : '0;
    dec_bundle.imm     = imm_zero_ext(opcode) ? {{(DATA_W-16){1'b0}}, imm16}
                                              : {{(DATA_W-16){imm16[15]}}, imm16};
    dec_bundle.shamt   = in_instr_i[SHAMT_HI:SHAMT_LO];
    dec_bundle.target  = in_instr_i[TGT_HI:TGT_LO];
    dec_bundle.dest    = dest;
    dec_bundle.wen     = has_dest && (dest != 5'd0);
    dec_bundle.pc      = in_pc_i;
    dec_bundle.illegal = (cls == ILLEGAL);
  end

  // A source is blocked if its busy bit survives this cycle's writeback,
  // or if the bundle still sitting in the output register will write it
  // (its busy bit is not set until it fires).
  logic rs_blocked, rt_blocked, hazard;

  assign rs_blocked = (busy_q[rs_a] && !(wb_en_i && (wb_addr_i == rs_a)))
                   || (out_valid_q && bundle_q.wen && (bundle_q.dest == rs_a));
  assign rt_blocked = (busy_q[rt_a] && !(wb_en_i && (wb_addr_i == rt_a)))
                   || (out_valid_q && bundle_q.wen && (bundle_q.dest == rt_a));
  assign hazard = (use_rs && (rs_a != 5'd0) && rs_blocked)
               || (use_rt && (rt_a != 5'd0) && rt_blocked);

  logic in_fire, out_fire;

  assign in_ready_o = (!out_valid_q || out_ready_i) && !(in_valid_i && hazard) && !flush_i;
  assign in_fire    = in_valid_i && in_ready_o;
  // A flushed bundle is dropped, never consumed
  assign out_fire   = out_valid_q && out_ready_i && !flush_i;

  // Clear then set so a same-cycle set on the same bit wins
  always_comb begin
    busy_d = busy_q;
    if (wb_en_i) busy_d[wb_addr_i] = 1'b0;
    if (out_fire && bundle_q.wen) busy_d[bundle_q.dest] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush_i)          out_valid_d = 1'b0;
    else if (in_fire)     out_valid_d = 1'b1;
    else if (out_ready_i) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      busy_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      if (in_fire) bundle_q <= dec_bundle;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_opcode_o  = bundle_q.opcode;
  assign out_rs_val_o  = bundle_q.rs_val;
  assign out_rt_val_o  = bundle_q.rt_val;
  assign out_imm_o     = bundle_q.imm;
  assign out_shamt_o   = bundle_q.shamt;
  assign out_target_o  = bundle_q.target;
  assign out_dest_o    = bundle_q.dest;
  assign out_wen_o     = bundle_q.wen;
  assign out_pc_o      = bundle_q.pc;
  assign out_illegal_o = bundle_q.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - self-checking bench for decode_issue
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr;
  logic [4:0]  in_pc;
  logic        out_valid, out_ready;
  logic [5:0]  out_opcode;
  logic [31:0] out_rs_val, out_rt_val, out_imm;
  logic [4:0]  out_shamt;
  logic [25:0] out_target;
  logic [4:0]  out_dest;
  logic        out_wen;
  logic [4:0]  out_pc;
  logic        out_illegal;
  logic        flush, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  decode_issue dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(in_instr), .in_pc_i(in_pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_opcode_o(out_opcode),
    .out_rs_val_o(out_rs_val), .out_rt_val_o(out_rt_val), .out_imm_o(out_imm),
    .out_shamt_o(out_shamt), .out_target_o(out_target), .out_dest_o(out_dest),
    .out_wen_o(out_wen), .out_pc_o(out_pc), .out_illegal_o(out_illegal),
    .flush_i(flush), .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data)
  );

  typedef struct {
    logic [5:0]  opcode;
    logic [31:0] rs_val, rt_val, imm;
    logic [4:0]  shamt;
    logic [25:0] target;
    logic [4:0]  dest;
    logic        wen;
    logic [4:0]  pc;
    logic        illegal;
  } bnd_t;

  // Reference state: architectural registers, busy set, held bundle
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic        m_valid;
  bnd_t        m_b;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy  = '0;
    m_valid = 1'b0;
    m_b     = '{default: '0};
  endtask

  function automatic logic [31:0] rd_reg(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  // One clock: compare at the falling edge, advance the model, resume after the rising edge
  task automatic step();
    int op;
    logic [4:0] rs, rt, rd, d;
    bit urs, urt, hd, haz, rdy;
    bnd_t nb;
    @(negedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("out_opcode", 32'(out_opcode), 32'(m_b.opcode));
        chk("out_rs_val", out_rs_val, m_b.rs_val);
        chk("out_rt_val", out_rt_val, m_b.rt_val);
        chk("out_imm", out_imm, m_b.imm);
        chk("out_shamt", 32'(out_shamt), 32'(m_b.shamt));
        chk("out_target", 32'(out_target), 32'(m_b.target));
        chk("out_dest", 32'(out_dest), 32'(m_b.dest));
        chk("out_wen", 32'(out_wen), 32'(m_b.wen));
        chk("out_pc", 32'(out_pc), 32'(m_b.pc));
        chk("out_illegal", 32'(out_illegal), 32'(m_b.illegal));
      end
      chk("busy", dut.busy_q, m_busy);

      op = int'(in_instr[31:26]);
      rs = in_instr[25:21]; rt = in_instr[20:16]; rd = in_instr[15:11];
      urs = 0; urt = 0; hd = 0; d = 0;
      if (op inside {0, 1, 2, 3, 6, 7, 23})       begin urs = 1; urt = 1; hd = 1; d = rd; end
      else if (op inside {4, 5, 8, 9, 24, 12})    begin urs = 1; hd = 1; d = rt; end
      else if (op inside {10, 11})                begin urt = 1; hd = 1; d = rd; end
      else if (op inside {[13:19]})               begin urs = 1; urt = 1; end
      else if (op == 21)                          urs = 1;
      else if (op == 22)                          begin hd = 1; d = 5'd31; end

      haz = 0;
      if (in_valid) begin
        if (urs && rs != 0 && ((m_busy[rs] && !(wb_en && wb_addr == rs)) ||
                               (m_valid && m_b.wen && m_b.dest == rs))) haz = 1;
        if (urt && rt != 0 && ((m_busy[rt] && !(wb_en && wb_addr == rt)) ||
                               (m_valid && m_b.wen && m_b.dest == rt))) haz = 1;
      end
      rdy = (!m_valid || out_ready) && !haz && !flush;
      chk("in_ready", 32'(in_ready), 32'(rdy));

      nb.opcode  = in_instr[31:26];
      nb.rs_val  = urs ? rd_reg(rs) : 32'd0;
      nb.rt_val  = urt ? rd_reg(rt) : 32'd0;
      nb.imm     = (op == 8 || op == 9) ? {16'd0, in_instr[15:0]}
                                        : {{16{in_instr[15]}}, in_instr[15:0]};
      nb.shamt   = in_instr[10:6];
      nb.target  = in_instr[25:0];
      nb.dest    = d;
      nb.wen     = hd && d != 0;
      nb.pc      = in_pc;
      nb.illegal = op > 24;

      if (wb_en) m_busy[wb_addr] = 1'b0;
      if (m_valid && out_ready && !flush && m_b.wen) m_busy[m_b.dest] = 1'b1;
      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
      if (flush) m_valid = 1'b0;
      else if (in_valid && rdy) begin m_valid = 1'b1; m_b = nb; end
      else if (out_ready) m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] rtype(input int op, input int rs, input int rt, input int rd);
    return {6'(op), 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  initial begin
    logic [4:0] busy_list [$];
    rst_n = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
    flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    model_reset();
    step(); step();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_opcode", 32'(out_opcode), 32'd0);
    chk("reset out_imm", out_imm, 32'd0);
    chk("reset busy", dut.busy_q, 32'd0);
    rst_n = 1;

    // addi r1, r0, 1000
    out_ready = 1; in_valid = 1; in_instr = itype(4, 0, 1, 1000); in_pc = 5'd3;
    step();
    chk("addi out_opcode", 32'(out_opcode), 32'd4);
    chk("addi out_imm", out_imm, 32'd1000);
    chk("addi out_dest", 32'(out_dest), 32'd1);
    chk("addi out_wen", 32'(out_wen), 32'd1);
    in_valid = 0;
    step();
    chk("addi busy1", 32'(dut.busy_q[1]), 32'd1);

    // add r3, r1, r2 stalls until r1 writes back, then uses the bypass
    in_valid = 1; in_instr = rtype(0, 1, 2, 3); in_pc = 5'd4;
    #1 chk("hazard in_ready", 32'(in_ready), 32'd0);
    step(); step();
    wb_en = 1; wb_addr = 1; wb_data = 1000;
    #1 chk("bypass in_ready", 32'(in_ready), 32'd1);
    step();
    wb_en = 0; in_valid = 0;
    chk("bypass out_rs_val", out_rs_val, 32'd1000);
    chk("bypass out_dest", 32'(out_dest), 32'd3);
    step();

    // Backpressure: ori r4 held, andi r5 waits
    out_ready = 0; in_valid = 1; in_instr = itype(9, 0, 4, 5); in_pc = 5'd5;
    step();
    in_instr = itype(8, 0, 5, 16'hFFF0); in_pc = 5'd6;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp held opcode", 32'(out_opcode), 32'd9);
      step();
    end
    out_ready = 1;
    #1 chk("bp release in_ready", 32'(in_ready), 32'd1);
    step();
    chk("andi opcode", 32'(out_opcode), 32'd8);
    chk("andi zero-ext imm", out_imm, 32'h0000FFF0);

    // slti sign-extends, write to r0 drops wen, illegal opcode
    in_instr = itype(24, 0, 6, 16'hFFF0);
    step();
    chk("slti sign-ext imm", out_imm, 32'hFFFFFFF0);
    in_instr = itype(4, 0, 0, 5);
    step();
    chk("r0 dest wen", 32'(out_wen), 32'd0);
    in_instr = itype(31, 1, 2, 7);
    step();
    chk("illegal flag", 32'(out_illegal), 32'd1);
    chk("illegal wen", 32'(out_wen), 32'd0);
    in_valid = 0;
    step();

    // Flush while held: bundle dropped, r7 never becomes busy
    out_ready = 0; in_valid = 1; in_instr = itype(4, 0, 7, 9);
    step();
    in_valid = 0; flush = 1;
    #1 chk("flush in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 0; out_ready = 1;
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush busy7", 32'(dut.busy_q[7]), 32'd0);

    // Async reset mid-stall with a held bundle
    in_valid = 1; in_instr = itype(4, 0, 2, 11);
    step();
    in_valid = 0;
    step();
    out_ready = 0; in_valid = 1; in_instr = itype(9, 0, 4, 7);
    step();
    in_instr = rtype(0, 2, 0, 3);
    step();
    #1 rst_n = 0;
    #1 chk("async out_valid", 32'(out_valid), 32'd0);
    chk("async busy", dut.busy_q, 32'd0);
    chk("async out_opcode", 32'(out_opcode), 32'd0);
    step();
    rst_n = 1; in_valid = 0; out_ready = 1;
    step();

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      in_instr  = $urandom;
      in_instr[31:26] = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(25, 63))
                                                    : 6'($urandom_range(0, 24));
      in_instr[25:21] = 5'($urandom_range(0, 7));
      in_instr[20:16] = 5'($urandom_range(0, 7));
      in_instr[15:11] = 5'($urandom_range(0, 7));
      in_pc   = 5'($urandom);
      wb_en   = ($urandom_range(0, 9) < 4);
      wb_data = $urandom;
      busy_list.delete();
      for (int r = 0; r < 32; r++) if (m_busy[r]) busy_list.push_back(5'(r));
      if (busy_list.size() > 0 && $urandom_range(0, 9) < 7)
        wb_addr = busy_list[$urandom_range(0, busy_list.size() - 1)];
      else
        wb_addr = 5'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
